ram_responder: RTL and testbench

- Memory-side responder for the CPU's data-RAM interface.
- Accepts the CPU's 6-bit address, 16-bit write data and write/read enables, and returns registered read data.
- Also services the special dump request raised by opcode 11111111 by streaming the whole RAM out, one word per cycle.
- Performs a self-clearing sweep after reset. Sits beside the CPU top, one instance per data RAM.

---
 rtl/ram_responder.sv | 118 +++++++++++
 tb/tb_ram_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// Data-RAM responder: single-cycle CPU read/write, a zeroing sweep after reset,
// and a full-RAM dump that streams one word per cycle.
module ram_responder #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64
) (
  input  logic              clk_main,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_enable,
  input  logic              read_enable,
  input  logic              dump_req,
  output logic [DATA_W-1:0] data_out,
  output logic              read_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_valid,
  output logic              busy
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_DUMP} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              read_valid_q, read_valid_d;
  logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;
  logic              dump_valid_q, dump_valid_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    data_out_d   = data_out_q;
    read_valid_d = 1'b0;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;
    dump_valid_d = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = address_in;
    mem_wdata    = data_in;
    unique case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST) state_d = S_IDLE;
      end
      S_IDLE: begin
        // Read sees the pre-write contents since the write lands at this same edge.
        mem_we = write_enable;
        if (read_enable) begin
          data_out_d   = mem[address_in];
          read_valid_d = 1'b1;
        end
        if (dump_req) begin
          state_d = S_DUMP;
          ptr_d   = '0;
        end
      end
      S_DUMP: begin
        dump_addr_d  = ptr_q;
        dump_data_d  = mem[ptr_q];
        dump_valid_d = 1'b1;
        ptr_d        = ptr_q + 1'b1;
        if (ptr_q == LAST) state_d = S_IDLE;
      end
      default: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_main) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      ptr_q        <= '0;
      data_out_q   <= '0;
      read_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      dump_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      data_out_q   <= data_out_d;
      read_valid_q <= read_valid_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
      dump_valid_q <= dump_valid_d;
    end
  end

  // No reset on the array; the CLEAR sweep zeroes it instead.
  always_ff @(posedge clk_main) begin
    if (!reset && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign data_out   = data_out_q;
  assign read_valid = read_valid_q;
  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_data_q;
  assign dump_valid = dump_valid_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: clear sweep, reads/writes, dump streaming,
// held-request retrigger and reset abort.
module tb_ram_responder;
  logic        clk_main = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  address_in = '0;
  logic [15:0] data_in = '0;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic        dump_req = 1'b0;
  logic [15:0] data_out;
  logic        read_valid;
  logic [5:0]  dump_addr;
  logic [15:0] dump_data;
  logic        dump_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] model [64];

  ram_responder dut (
    .clk_main(clk_main), .reset(reset), .address_in(address_in), .data_in(data_in),
    .write_enable(write_enable), .read_enable(read_enable), .dump_req(dump_req),
    .data_out(data_out), .read_valid(read_valid), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_valid(dump_valid), .busy(busy)
  );

  always #5 clk_main = ~clk_main;

  task automatic tick();
    @(posedge clk_main);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [5:0] a, input logic [15:0] d);
    address_in = a; data_in = d; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    model[a] = d;
  endtask

  task automatic do_read(input string tag, input logic [5:0] a, input logic [15:0] exp);
    address_in = a; read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
    chk({tag, "_valid"}, 32'(read_valid), 32'd1);
    chk({tag, "_data"}, 32'(data_out), 32'(exp));
    tick();
    chk({tag, "_valid_drop"}, 32'(read_valid), 32'd0);
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(n), 32'd64);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) model[i] = '0;

    // 1: reset state and clear sweep
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_read_valid", 32'(read_valid), 32'd0);
    chk("rst_dump_valid", 32'(dump_valid), 32'd0);
    chk("rst_dump_addr", 32'(dump_addr), 32'd0);
    chk("rst_dump_data", 32'(dump_data), 32'd0);
    count_busy("clear_len");
    do_read("rd0", 6'd0, 16'h0000);
    do_read("rd31", 6'd31, 16'h0000);
    do_read("rd63", 6'd63, 16'h0000);

    // 2: write then read
    do_write(6'd5, 16'hBEEF);
    do_read("rd5", 6'd5, 16'hBEEF);
    do_read("rd6", 6'd6, 16'h0000);

    // 3: same-cycle read/write returns old data
    do_write(6'd9, 16'h1111);
    address_in = 6'd9; data_in = 16'h2222; write_enable = 1'b1; read_enable = 1'b1;
    tick();
    write_enable = 1'b0; read_enable = 1'b0;
    model[9] = 16'h2222;
    chk("rbw_valid", 32'(read_valid), 32'd1);
    chk("rbw_old", 32'(data_out), 32'h1111);
    tick();
    do_read("rbw_new", 6'd9, 16'h2222);

    // 4 + 5: single-pulse dump with ignored CPU strobes
    do_write(6'd0, 16'h00AA);
    do_write(6'd63, 16'h5555);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    chk("dump_busy_start", 32'(busy), 32'd1);
    for (int i = 0; i < 64; i++) begin
      if (i == 10) begin
        address_in = 6'd3; data_in = 16'hFFFF; write_enable = 1'b1; read_enable = 1'b1;
      end
      if (i == 13) begin
        write_enable = 1'b0; read_enable = 1'b0;
      end
      tick();
      chk($sformatf("dump_valid_%0d", i), 32'(dump_valid), 32'd1);
      chk($sformatf("dump_addr_%0d", i), 32'(dump_addr), 32'(i));
      chk($sformatf("dump_data_%0d", i), 32'(dump_data), 32'(model[i]));
      chk($sformatf("dump_rv_%0d", i), 32'(read_valid), 32'd0);
      if (i < 63) chk($sformatf("dump_busy_%0d", i), 32'(busy), 32'd1);
    end
    chk("dump_end_busy", 32'(busy), 32'd0);
    tick();
    chk("dump_end_valid", 32'(dump_valid), 32'd0);
    do_read("rd3_after", 6'd3, 16'h0000);

    // held request: one IDLE cycle, then a second dump; reset aborts it at word 20
    dump_req = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) tick();
    chk("held_last_addr", 32'(dump_addr), 32'd63);
    chk("held_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("held_gap_valid", 32'(dump_valid), 32'd0);
    chk("held_gap_busy", 32'(busy), 32'd1);
    tick();
    dump_req = 1'b0;
    chk("retrig_valid", 32'(dump_valid), 32'd1);
    chk("retrig_addr", 32'(dump_addr), 32'd0);
    for (int i = 1; i <= 20; i++) tick();
    chk("abort_addr", 32'(dump_addr), 32'd20);
    chk("abort_data", 32'(dump_data), 32'(model[20]));

    // 6: reset mid-dump
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_dump_valid", 32'(dump_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    count_busy("reclear_len");
    for (int i = 0; i < 64; i++) model[i] = '0;
    do_read("rd0_cleared", 6'd0, 16'h0000);
    do_read("rd5_cleared", 6'd5, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
